// File: rtl/shift_load_arbiter.sv
// rtl/shift_load_arbiter.sv - two-requester round-robin parallel-load, MSB-first serial shifter
module shift_load_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    output logic [1:0]       gnt,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             src,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ptr_q, ptr_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             src_q, src_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             idx;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        shreg_d = shreg_q;
        src_d   = src_q;
        gnt_d   = 2'b00;
        idx     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    // Contention resolves to the pointer; a lone request wins outright.
                    idx     = (req == 2'b11) ? ptr_q : req[1];
                    shreg_d = idx ? din1 : din0;
                    src_d   = idx;
                    gnt_d   = idx ? 2'b10 : 2'b01;
                    cnt_d   = '0;
                    ptr_d   = ~idx;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sout_ready) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= 1'b0;
            shreg_q <= '0;
            src_q   <= 1'b0;
            gnt_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            shreg_q <= shreg_d;
            src_q   <= src_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt        = gnt_q;
    assign q          = shreg_q;
    assign sout       = shreg_q[WIDTH-1];
    assign sout_valid = (state_q == ST_SHIFT);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign src        = src_q;

endmodule

// File: tb/tb_shift_load_arbiter.sv
// tb/tb_shift_load_arbiter.sv - scoreboard bench for shift_load_arbiter at WIDTH 4 and 8
module tb_shift_load_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [3:0] din0, din1;
    logic [1:0] gnt;
    logic [3:0] q;
    logic       sout, sout_valid, rdy, src, busy, done;

    logic [1:0] req8;
    logic [7:0] d80, d81, q8;
    logic [1:0] gnt8;
    logic       sout8, sv8, rdy8, src8, busy8, done8;

    int checks   = 0;
    int failures = 0;
    bit exp_q4[$];
    bit exp_q8[$];

    always #5 clk = ~clk;

    shift_load_arbiter #(.WIDTH(4)) u_dut (
        .clk(clk), .rst(rst), .req(req), .din0(din0), .din1(din1),
        .gnt(gnt), .q(q), .sout(sout), .sout_valid(sout_valid),
        .sout_ready(rdy), .src(src), .busy(busy), .done(done)
    );

    shift_load_arbiter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .req(req8), .din0(d80), .din1(d81),
        .gnt(gnt8), .q(q8), .sout(sout8), .sout_valid(sv8),
        .sout_ready(rdy8), .src(src8), .busy(busy8), .done(done8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push4(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) exp_q4.push_back(w[i]);
    endtask

    // Scores bits that transfer at the coming edge, then advances one cycle.
    task automatic tick();
        if (sout_valid && rdy) begin
            if (exp_q4.size() == 0) chk("sb4_underflow", 1, 0);
            else chk("sout4", {31'd0, sout}, {31'd0, exp_q4.pop_front()});
        end
        if (sv8 && rdy8) begin
            if (exp_q8.size() == 0) chk("sb8_underflow", 1, 0);
            else chk("sout8", {31'd0, sout8}, {31'd0, exp_q8.pop_front()});
        end
        chk("gnt_onehot", {31'd0, gnt == 2'b11}, 0);
        chk("gnt_done_excl", {31'd0, (|gnt) && done}, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b0; req = 2'b00; din0 = '0; din1 = '0; rdy = 1'b1;
        req8 = 2'b00; d80 = '0; d81 = '0; rdy8 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        chk("rst_q", q, 0);
        chk("rst_sout", sout, 0);
        chk("rst_valid", sout_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_src", src, 0);
        rst = 1'b1;

        // Single load from requester 0
        req = 2'b01; din0 = 4'b1011; push4(4'b1011);
        tick();
        chk("single_gnt", gnt, 2'b01);
        chk("single_src", src, 0);
        chk("single_busy", busy, 1);
        req = 2'b00;
        ticks(4);
        chk("single_done", done, 1);
        chk("single_done_valid", sout_valid, 0);
        chk("single_done_q", q, 0);
        chk("single_done_busy", busy, 1);
        tick();
        chk("single_idle_done", done, 0);
        chk("single_idle_busy", busy, 0);

        // Contention from a fresh pointer
        rst = 1'b0; tick(); rst = 1'b1;
        req = 2'b11; din0 = 4'hA; din1 = 4'h5;
        push4(4'hA); push4(4'h5); push4(4'hA);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("cont_gnt", gnt, (k == 1) ? 2'b10 : 2'b01);
            chk("cont_src", src, (k == 1) ? 1 : 0);
            if (k == 2) req = 2'b00;
            ticks(4);
            chk("cont_done", done, 1);
            tick();
        end
        chk("cont_idle", busy, 0);

        // Backpressure on the 2nd and 3rd SHIFT cycles
        req = 2'b01; din0 = 4'b1100; push4(4'b1100);
        tick();
        chk("bp_gnt", gnt, 2'b01);
        req = 2'b00;
        tick();
        rdy = 1'b0;
        tick();
        chk("bp_hold_sout", sout, 1);
        chk("bp_hold_valid", sout_valid, 1);
        tick();
        chk("bp_hold_q", q, 4'b1000);
        rdy = 1'b1;
        ticks(2);
        chk("bp_not_done_yet", done, 0);
        tick();
        chk("bp_done", done, 1);
        tick();

        // Late request during another requester's shift
        req = 2'b01; din0 = 4'h3; push4(4'h3);
        tick();
        chk("late_gnt0", gnt, 2'b01);
        req = 2'b00;
        tick();
        req = 2'b10; din1 = 4'h6; push4(4'h6);
        tick();
        chk("late_no_gnt_shift", gnt, 0);
        ticks(2);
        chk("late_done", done, 1);
        chk("late_no_gnt_done", gnt, 0);
        tick();
        chk("late_idle_gnt", gnt, 0);
        chk("late_idle_busy", busy, 0);
        tick();
        chk("late_gnt1", gnt, 2'b10);
        chk("late_src", src, 1);
        req = 2'b00;
        ticks(4);
        chk("late_done2", done, 1);
        tick();

        // Reset after two bits of 4'hF
        req = 2'b01; din0 = 4'hF;
        exp_q4.push_back(1'b1); exp_q4.push_back(1'b1);
        tick();
        chk("rst_mid_gnt", gnt, 2'b01);
        req = 2'b00;
        ticks(2);
        rst = 1'b0; rdy = 1'b0;
        tick();
        chk("rst_mid_q", q, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_valid", sout_valid, 0);
        rst = 1'b1; rdy = 1'b1;
        req = 2'b10; din1 = 4'h9; push4(4'h9);
        tick();
        chk("rst_mid_gnt_after", gnt, 2'b10);
        chk("rst_mid_src_after", src, 1);
        req = 2'b00;
        ticks(4);
        chk("rst_mid_done_after", done, 1);
        tick();

        // WIDTH=8 single load, period WIDTH+2
        req8 = 2'b10; d81 = 8'h81;
        for (int i = 7; i >= 0; i--) exp_q8.push_back(d81[i]);
        tick();
        chk("w8_gnt", gnt8, 2'b10);
        chk("w8_src", src8, 1);
        req8 = 2'b00;
        ticks(7);
        chk("w8_not_done", done8, 0);
        tick();
        chk("w8_done", done8, 1);
        chk("w8_q", q8, 0);
        tick();
        chk("w8_idle", busy8, 0);

        chk("sb4_drained", exp_q4.size(), 0);
        chk("sb8_drained", exp_q8.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
